// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between mem_stage and the data memory.
interface mem_stage_if #(parameter int DATA_W = 32);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_stage.sv
// Beta CPU memory-access stage: one held instruction, variable-latency memory
// handshake with timeout, misalignment/fault conversion into an exception instruction.
module mem_stage #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 16,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] d,
    input  logic [31:0]       ir,
    input  logic              exc_in,
    output logic              stall,
    output logic [DATA_W-1:0] pc_next,
    output logic [DATA_W-1:0] y_next,
    output logic [31:0]       ir_next,
    output logic              exc_out,
    output logic              op_ld_or_ldr,
    output logic              op_st,
    output logic              op_br_or_jmp,
    mem_stage_if.master       mem
);
    // NOP = ADD(R31,R31,R31); exception = BNE(R31,0,XP)
    localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
    localparam logic [31:0] INST_BNE_EXCEPT = 32'h77DF_0000;
    localparam int          AW              = $clog2(DATA_W / 8);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] d;
        logic [31:0]       ir;
        logic              exc;
    } stage_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    stage_t            q;
    state_t            state, state_d;
    logic [7:0]        cnt;
    logic              tmo;
    logic [DATA_W-1:0] rdata_q;
    logic              req;

    logic [5:0] opcode;
    logic       is_ld, is_st, misaligned, mem_op, timeout_hit;

    assign opcode       = q.ir[31:26];
    assign is_ld        = (opcode == 6'b011000) || (opcode == 6'b011111);
    assign is_st        = (opcode == 6'b011001);
    assign op_ld_or_ldr = is_ld;
    assign op_st        = is_st;
    assign op_br_or_jmp = (opcode == 6'b011011) || (opcode == 6'b011100) || (opcode == 6'b011101);

    assign misaligned  = CHECK_ALIGN && (is_ld || is_st) && (q.y[AW-1:0] != '0);
    assign mem_op      = (is_ld || is_st) && !q.exc && !misaligned;
    // cnt is 0 in the request's IDLE cycle and k in its k-th BUSY cycle
    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));
    assign stall       = ((state == IDLE) && mem_op) || (state == BUSY);

    always_comb begin
        state_d = state;
        req     = 1'b0;
        case (state)
            IDLE: if (mem_op) begin
                req     = 1'b1;
                state_d = mem.mem_ack ? DONE : BUSY;
            end
            BUSY: begin
                req = 1'b1;
                if (mem.mem_ack || timeout_hit) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            q.pc    <= '0;
            q.y     <= '0;
            q.d     <= '0;
            q.ir    <= INST_NOP;
            q.exc   <= 1'b0;
            cnt     <= '0;
            tmo     <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_d;
            if (!stall) begin
                q.pc  <= pc;
                q.y   <= y;
                q.d   <= d;
                q.ir  <= ir;
                q.exc <= exc_in;
            end
            cnt <= stall ? cnt + 8'd1 : 8'd0;
            tmo <= (state == BUSY) && !mem.mem_ack && timeout_hit;
            if (req && mem.mem_ack && is_ld) rdata_q <= mem.mem_rdata;
        end
    end

    always_comb begin
        ir_next = q.ir;
        exc_out = 1'b0;
        if (q.exc) begin
            ir_next = INST_NOP;
            exc_out = 1'b1;
        end else if (misaligned || ((state == DONE) && tmo)) begin
            ir_next = INST_BNE_EXCEPT;
            exc_out = 1'b1;
        end else if (stall) begin
            ir_next = INST_NOP;
        end
    end

    assign pc_next = q.pc;
    assign y_next  = ((state == DONE) && is_ld) ? rdata_q : q.y;

    assign mem.mem_req   = req;
    assign mem.mem_we    = req && is_st;
    assign mem.mem_addr  = q.y;
    assign mem.mem_wdata = q.d;
endmodule
